// File: rtl/wb_stage_if.sv
// wb_stage_if: M-stage inputs and W-stage results of the writeback stage.
interface wb_stage_if #(
  parameter int CNT_W = 32
);
  logic             M_valid;
  logic [31:0]      M_Instr;
  logic [31:0]      M_ALUResult;
  logic [31:0]      M_DMRD;
  logic [31:0]      M_PC;
  logic [31:0]      M_HI;
  logic [31:0]      M_LO;
  logic             W_valid;
  logic             W_RegWrite;
  logic [4:0]       W_A3;
  logic [31:0]      W_WD;
  logic [31:0]      W_PC;
  logic             retire;
  logic [CNT_W-1:0] retire_cnt;
  modport master (
    output M_valid, M_Instr, M_ALUResult, M_DMRD, M_PC, M_HI, M_LO,
    input  W_valid, W_RegWrite, W_A3, W_WD, W_PC, retire, retire_cnt
  );
  modport slave (
    input  M_valid, M_Instr, M_ALUResult, M_DMRD, M_PC, M_HI, M_LO,
    output W_valid, W_RegWrite, W_A3, W_WD, W_PC, retire, retire_cnt
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MIPS writeback register with result select, load extraction, link value and retire counter.
module wb_stage #(
  parameter int          CNT_W    = 32,
  parameter logic [31:0] LINK_OFS = 32'd8,
  parameter bit          HILO_EN  = 1'b1
) (
  input logic       clk,
  input logic       reset,
  input logic       stall,
  input logic       flush,
  wb_stage_if.slave bus
);
  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] dmrd;
    logic [31:0] pc;
    logic [31:0] hi;
    logic [31:0] lo;
  } w_t;
  w_t w, m;
  logic [CNT_W-1:0] cnt;
  logic is_r, is_load, is_ialu, is_jal, is_jalr, is_mfhi, is_mflo, r_wr, wr, retire;
  logic [4:0] a3;
  logic [15:0] half;
  logic [7:0] byt;
  logic [31:0] ld, wd;
  // Only the instruction fields the writeback decode needs are kept.
  assign m = {bus.M_valid, bus.M_Instr[31:26], bus.M_Instr[5:0], bus.M_Instr[20:16],
              bus.M_Instr[15:11], bus.M_ALUResult, bus.M_DMRD, bus.M_PC, bus.M_HI, bus.M_LO};
  always_ff @(posedge clk or negedge reset)
    if (!reset) w <= '0;
    else if (flush) w <= '0;
    else if (!stall) w <= m;
  assign retire = w.valid && !stall;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (retire && !(&cnt)) cnt <= cnt + 1'b1;
  assign is_r    = w.op == 6'h00;
  assign is_load = w.op inside {6'h23, 6'h21, 6'h25, 6'h20, 6'h24};
  assign is_ialu = w.op inside {6'h0d, 6'h08, 6'h0c, 6'h0f, 6'h0a};
  assign is_jal  = w.op == 6'h03;
  assign is_jalr = is_r && w.fn == 6'h09;
  assign is_mfhi = is_r && w.fn == 6'h10;
  assign is_mflo = is_r && w.fn == 6'h12;
  // R-type that write rd: everything except jr, mult/div family and mthi/mtlo.
  assign r_wr = is_r && !(w.fn inside {6'h08, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h11, 6'h13});
  assign a3 = (is_load || is_ialu) ? w.rt : is_jal ? 5'd31 : r_wr ? w.rd : 5'd0;
  assign wr = (is_load || is_ialu || is_jal || r_wr) && (HILO_EN || !(is_mfhi || is_mflo));
  assign half = w.alu[1] ? w.dmrd[31:16] : w.dmrd[15:0];
  assign byt  = 8'(w.dmrd >> {w.alu[1:0], 3'b000});
  assign ld = w.op == 6'h23 ? w.dmrd :
              w.op == 6'h21 ? {{16{half[15]}}, half} :
              w.op == 6'h25 ? {16'h0, half} :
              w.op == 6'h20 ? {{24{byt[7]}}, byt} : {24'h0, byt};
  assign wd = is_load ? ld : (is_jal || is_jalr) ? w.pc + LINK_OFS :
              is_mfhi ? w.hi : is_mflo ? w.lo : w.alu;
  assign bus.W_valid    = w.valid;
  assign bus.W_RegWrite = w.valid && wr && a3 != 5'd0;
  assign bus.W_A3       = a3;
  assign bus.W_WD       = wd;
  assign bus.W_PC       = w.pc;
  assign bus.retire     = retire;
  assign bus.retire_cnt = cnt;
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have parameter LINK_OFS, default 8: offset added to PC for the link value (8 = delay slot, 4 = none).
REQ-003 SHALL have parameter HILO_EN, default 1: when 0, mfhi/mflo do not write the register file.
REQ-004 SHALL have ports clk, in, 1, clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, in, 1, asynchronous active-low reset.
REQ-006 SHALL have ports stall and flush, in, 1 each: W-register hold and bubble insert.
REQ-007 SHALL have ports M_valid (in, 1) and M_Instr (in, 32).
REQ-008 SHALL have ports M_ALUResult, M_DMRD, M_PC, M_HI and M_LO, in, 32 each.
REQ-009 SHALL have ports W_valid (out, 1), W_RegWrite (out, 1), W_A3 (out, 5) and W_WD (out, 32).
REQ-010 SHALL have ports W_PC (out, 32), retire (out, 1) and retire_cnt (out, CNT_W).

Function
REQ-011 SHALL hold a W register {valid, Instr, ALUResult, DMRD, PC, HI, LO}, loaded from M_* at a rising edge when flush=0 and stall=0.
REQ-012 SHALL load a bubble (valid=0, all fields 0) when flush=1, regardless of stall; flush has priority.
REQ-013 SHALL keep the W register unchanged when stall=1 and flush=0.
REQ-014 SHALL drive all outputs except retire_cnt combinationally from the W register, giving 1-cycle latency from M inputs.
REQ-015 SHALL decode the write source as: LOAD for lw/lh/lhu/lb/lbu; LINK for jal/jalr; HI for mfhi; LO for mflo; ALU otherwise.
REQ-016 SHALL decode these opcodes: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, jal 000011.
REQ-017 SHALL decode these R-type funct codes (opcode 000000): jalr 001001, mfhi 010000, mflo 010010.
REQ-018 SHALL extract load data with off = ALUResult[1:0]: lw returns DMRD unchanged (off ignored).
REQ-019 SHALL, for lh/lhu, select halfword DMRD[16*off[1]+:16], sign-extended for lh and zero-extended for lhu; off[0] is ignored.
REQ-020 SHALL, for lb/lbu, select byte DMRD[8*off+:8], sign-extended for lb and zero-extended for lbu.
REQ-021 SHALL set the LINK value to PC+LINK_OFS, wrapping modulo 2^32.
REQ-022 SHALL select W_A3 as: rt for loads and I-type ALU ops (ori, addi, andi, lui, slti); 31 for jal; rd for R-type writers; 0 otherwise.
REQ-023 SHALL treat jr, mult/multu/div/divu, mthi/mtlo, stores, branches and j as non-writing, with W_A3=0.
REQ-024 SHALL drive W_RegWrite=1 only when valid=1, the instruction writes, and W_A3!=0.
REQ-025 SHALL, when HILO_EN=0, drive W_RegWrite=0 for mfhi/mflo.
REQ-026 SHALL drive W_WD as the selected source value even when W_RegWrite=0, so it is always a defined value.
REQ-027 SHALL assert retire=1 in a cycle when W_valid=1 and stall=0, meaning the instruction leaves W at the next edge.
REQ-028 SHALL increment retire_cnt by 1 at each edge where retire=1, saturating at all-ones with no wrap.
REQ-029 SHALL apply flush without clearing retire for the instruction currently in W; that instruction still retires.
REQ-030 SHALL ignore unknown opcodes, treating them as non-writing with the ALU source.

Reset
REQ-031 SHALL clear the W register and retire_cnt to 0 immediately while reset=0, independent of clk.
REQ-032 SHALL drive outputs during and after reset, until the first load: W_valid=0, W_RegWrite=0, W_A3=0, W_WD=0, W_PC=0, retire=0.
REQ-033 SHALL discard an in-flight instruction when reset asserts mid-operation; the first load after reset is taken at the first rising edge with reset=1.

Verification
REQ-034 SHALL cover lb with DMRD=0x80FF7F01 and ALUResult low bits 01: W_WD=0x0000007F; same case with off=11 gives 0xFFFFFF80; lbu off=11 gives 0x00000080.
REQ-035 SHALL cover lh with DMRD=0x8001FFFE and off=10: W_WD=0xFFFF8001; lhu gives 0x00008001.
REQ-036 SHALL cover jal with PC=0x00003000 and LINK_OFS=8: W_A3=31, W_WD=0x00003008, W_RegWrite=1; PC=0xFFFFFFFC gives W_WD=0x00000004.
REQ-037 SHALL cover addu with rd=0: W_RegWrite=0, W_WD=ALUResult.
REQ-038 SHALL cover mfhi with HI=0x12345678: W_WD=0x12345678 and W_RegWrite=1; with HILO_EN=0, W_RegWrite=0.
REQ-039 SHALL cover 3 valid instructions with stall=1 for 2 cycles in between: retire_cnt ends at 3; the W register holds during stall; flush+stall together loads a bubble.
REQ-040 SHALL cover CNT_W=4 with 20 retirements: retire_cnt=15; asserting reset mid-stream clears retire_cnt and W_valid asynchronously.
